// File: rtl/wrapper_pkg.sv
// -----------------------------------------------------------------------------
// wrapper_pkg
// Shared types for the accelerator wrapper AHB ports:
//   - htrans_t       : AHB-Lite transfer type encoding
//   - HRESP_*        : AHB-Lite response encoding
//   - HSIZE_*        : transfer size encodings used by the packet builder
//   - dphase_state_t : data-phase FSM state of the packet builder
//   - lane_mask()    : byte-lane enable for a (size, addr[1:0]) pair
// -----------------------------------------------------------------------------
package wrapper_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_STALL = 3'd2,
    ST_ERR1  = 3'd3,
    ST_ERR2  = 3'd4
  } dphase_state_t;

  // Byte lanes touched by an aligned access; lanes follow the address, so a
  // byte at offset 1 lives on hwdata[15:8].
  function automatic logic [3:0] lane_mask(input logic [2:0] size,
                                           input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << addr_lo;
      HSIZE_HALF: mask = 4'b0011 << addr_lo;
      default:    mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/wrapper_packet_fifo.sv
// -----------------------------------------------------------------------------
// wrapper_packet_fifo
// DEPTH-entry FIFO of WIDTH-bit packets with a registered head entry.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write request and data (ignored when full without pop)
//   pop               remove head entry (ignored when empty)
//   head_data         registered copy of the oldest entry
//   head_valid        registered "not empty"
//   full, empty       occupancy flags
//   count             occupied entries
// -----------------------------------------------------------------------------
module wrapper_packet_fifo #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       head_valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTRW-1:0]  rd_ptr_r;
  logic [PTRW-1:0]  wr_ptr_r;
  logic [CNTW-1:0]  count_r;
  logic [CNTW-1:0]  count_s;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_s;
  logic             head_valid_r;
  logic             head_load_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    if (p == PTRW'(DEPTH - 1)) begin
      return {PTRW{1'b0}};
    end else begin
      return p + PTRW'(1);
    end
  endfunction

  // Qualified push/pop and next occupancy.
  always_comb begin
    pop_ok_s  = pop & (count_r != {CNTW{1'b0}});
    push_ok_s = push & ((count_r != CNTW'(DEPTH)) | pop_ok_s);
    count_s   = count_r;
    if (push_ok_s & ~pop_ok_s) begin
      count_s = count_r + CNTW'(1);
    end else if (pop_ok_s & ~push_ok_s) begin
      count_s = count_r - CNTW'(1);
    end else begin
      count_s = count_r;
    end
  end

  // Next head: the pushed packet when it becomes the oldest entry, otherwise
  // the entry behind the current head after a pop.
  always_comb begin
    head_s      = head_r;
    head_load_s = 1'b0;
    if (push_ok_s && ((count_r == {CNTW{1'b0}}) ||
                      (pop_ok_s && (count_r == CNTW'(1))))) begin
      head_s      = push_data;
      head_load_s = 1'b1;
    end else if (pop_ok_s && (count_r > CNTW'(1))) begin
      head_s      = mem_r[ptr_inc(rd_ptr_r)];
      head_load_s = 1'b1;
    end else begin
      head_s      = head_r;
      head_load_s = 1'b0;
    end
  end

  // Storage, pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      rd_ptr_r     <= {PTRW{1'b0}};
      wr_ptr_r     <= {PTRW{1'b0}};
      count_r      <= {CNTW{1'b0}};
      head_r       <= {WIDTH{1'b0}};
      head_valid_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      if (head_load_s) begin
        head_r <= head_s;
      end
      count_r      <= count_s;
      head_valid_r <= (count_s != {CNTW{1'b0}});
    end
  end

  assign head_data  = head_r;
  assign head_valid = head_valid_r;
  assign full       = (count_r == CNTW'(DEPTH));
  assign empty      = (count_r == {CNTW{1'b0}});
  assign count      = count_r;

endmodule

// File: rtl/wrapper_ahb_packet_builder.sv
// -----------------------------------------------------------------------------
// wrapper_ahb_packet_builder
// AHB-Lite write port that assembles 32-bit beats into PACKETWIDTH-bit packets,
// buffers up to DEPTH completed packets and streams them to the engine.
//
// Configuration macro: WRAPPER_PACKET_BUILDER_SUBWORD_EN
//   defined   : byte/halfword writes accepted (naturally aligned), merged by
//               byte-lane mask; a write covering lane 3 of the top word
//               completes the packet.
//   undefined : only aligned word writes accepted; anything else errors.
//
// Ports:
//   HCLK, HRESETn                  clock, asynchronous active-low reset
//   hsels..hwdatas                 AHB-Lite target inputs
//   hreadyouts, hresps, hrdatas    AHB-Lite target outputs (reads return 0)
//   packet_data(_last/_valid)      FIFO head packet towards the engine
//   packet_data_ready              engine accepts the head packet
//   data_req                       DMA request: FIFO has room
//   fifo_count                     occupied FIFO entries
// -----------------------------------------------------------------------------
module wrapper_ahb_packet_builder
  import wrapper_pkg::*;
#(
  parameter int ADDRWIDTH   = 11,
  parameter int PACKETWIDTH = 512,
  parameter int DEPTH       = 2
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       hsels,
  input  logic [ADDRWIDTH-1:0]       haddrs,
  input  logic [1:0]                 htranss,
  input  logic [2:0]                 hsizes,
  input  logic                       hwrites,
  input  logic                       hreadys,
  input  logic [31:0]                hwdatas,
  output logic                       hreadyouts,
  output logic                       hresps,
  output logic [31:0]                hrdatas,
  output logic [PACKETWIDTH-1:0]     packet_data,
  output logic                       packet_data_last,
  output logic                       packet_data_valid,
  input  logic                       packet_data_ready,
  output logic                       data_req,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PKTBYTEW = $clog2(PACKETWIDTH / 8);
  localparam int WORDS    = PACKETWIDTH / 32;
  localparam int WIDXW    = PKTBYTEW - 2;
  localparam int CNTW     = $clog2(DEPTH + 1);

  dphase_state_t              state_r;
  dphase_state_t              state_s;
  dphase_state_t              capture_next_s;
  logic [ADDRWIDTH-1:2]       addr_word_r;
  logic                       addr_capture_s;
  logic                       data_phase_s;
  logic [WIDXW-1:0]           word_idx_s;
  logic [3:0]                 beat_mask_s;
  logic                       complete_s;
  logic                       last_s;
  logic                       push_s;
  logic                       pop_s;
  logic                       push_blocked_s;
  logic [PACKETWIDTH-1:0]     buf_r;
  logic [PACKETWIDTH-1:0]     merged_s;
  logic                       fifo_full_s;
  logic                       fifo_empty_s;
  logic [PACKETWIDTH:0]       fifo_head_s;
  logic [CNTW-1:0]            fifo_count_next_s;
  logic                       data_req_r;
  logic                       hreadyout_s;
  logic                       hresp_s;

`ifdef WRAPPER_PACKET_BUILDER_SUBWORD_EN
  logic [1:0]                 addr_lo_r;
  logic [2:0]                 size_r;
`endif

  // Whether a write of this size/offset is accepted by the port.
  function automatic logic access_ok(input logic [2:0] size,
                                     input logic [1:0] addr_lo);
    logic ok;
`ifdef WRAPPER_PACKET_BUILDER_SUBWORD_EN
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr_lo[0];
      HSIZE_WORD: ok = (addr_lo == 2'b00);
      default:    ok = 1'b0;
    endcase
`else
    ok = (size == HSIZE_WORD) && (addr_lo == 2'b00);
`endif
    return ok;
  endfunction

  // Address phase qualification and the state a captured transfer leads to.
  always_comb begin
    addr_capture_s = hsels & hreadys &
                     ((htrans_t'(htranss) == HTRANS_NONSEQ) ||
                      (htrans_t'(htranss) == HTRANS_SEQ));
    if (addr_capture_s && hwrites) begin
      if (access_ok(hsizes, haddrs[1:0])) begin
        capture_next_s = ST_WRITE;
      end else begin
        capture_next_s = ST_ERR1;
      end
    end else begin
      capture_next_s = ST_IDLE;
    end
  end

  // Address-phase capture for the following data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_word_r <= {(ADDRWIDTH-2){1'b0}};
`ifdef WRAPPER_PACKET_BUILDER_SUBWORD_EN
      addr_lo_r   <= 2'b00;
      size_r      <= 3'b000;
`endif
    end else if (addr_capture_s) begin
      addr_word_r <= haddrs[ADDRWIDTH-1:2];
`ifdef WRAPPER_PACKET_BUILDER_SUBWORD_EN
      addr_lo_r   <= haddrs[1:0];
      size_r      <= hsizes;
`endif
    end
  end

  // Data-phase decode: which word/lanes this beat hits and whether it ends
  // the packet. The top packet slot of the window marks the block's last one.
  always_comb begin
    data_phase_s = (state_r == ST_WRITE) || (state_r == ST_STALL);
    word_idx_s   = addr_word_r[PKTBYTEW-1:2];
`ifdef WRAPPER_PACKET_BUILDER_SUBWORD_EN
    beat_mask_s  = lane_mask(size_r, addr_lo_r);
`else
    beat_mask_s  = 4'b1111;
`endif
    complete_s   = data_phase_s && (word_idx_s == WIDXW'(WORDS - 1)) &&
                   beat_mask_s[3];
    last_s       = &addr_word_r[ADDRWIDTH-1:PKTBYTEW];
  end

  // Push handshake; a pop in the same cycle frees a slot for a full FIFO.
  always_comb begin
    pop_s          = packet_data_valid & packet_data_ready & ~fifo_empty_s;
    push_blocked_s = fifo_full_s & ~pop_s;
    push_s         = complete_s & ~push_blocked_s;
  end

  // Assembly buffer with the current beat merged in by byte lane.
  always_comb begin
    merged_s = buf_r;
    for (int w = 0; w < WORDS; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (data_phase_s && (word_idx_s == WIDXW'(w)) && beat_mask_s[b]) begin
          merged_s[w*32 + b*8 +: 8] = hwdatas[b*8 +: 8];
        end else begin
          merged_s[w*32 + b*8 +: 8] = buf_r[w*32 + b*8 +: 8];
        end
      end
    end
  end

  // Assembly buffer: cleared on push so unwritten words of the next packet
  // read as zero; a stalled completing beat is held on the bus, not here.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      buf_r <= {PACKETWIDTH{1'b0}};
    end else if (push_s) begin
      buf_r <= {PACKETWIDTH{1'b0}};
    end else if (data_phase_s && !complete_s) begin
      buf_r <= merged_s;
    end
  end

  // Data-phase FSM: state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Data-phase FSM: next state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: state_s = capture_next_s;
      ST_WRITE: begin
        if (complete_s && push_blocked_s) begin
          state_s = ST_STALL;
        end else begin
          state_s = capture_next_s;
        end
      end
      ST_STALL: begin
        if (push_blocked_s) begin
          state_s = ST_STALL;
        end else begin
          state_s = capture_next_s;
        end
      end
      ST_ERR1: state_s = ST_ERR2;
      ST_ERR2: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Data-phase FSM: bus response. Wait states only while a completing beat
  // cannot be pushed, plus the first cycle of the two-cycle ERROR.
  always_comb begin
    hreadyout_s = 1'b1;
    hresp_s     = HRESP_OKAY;
    case (state_r)
      ST_IDLE: begin
        hreadyout_s = 1'b1;
        hresp_s     = HRESP_OKAY;
      end
      ST_WRITE: begin
        hreadyout_s = ~(complete_s & push_blocked_s);
        hresp_s     = HRESP_OKAY;
      end
      ST_STALL: begin
        hreadyout_s = ~push_blocked_s;
        hresp_s     = HRESP_OKAY;
      end
      ST_ERR1: begin
        hreadyout_s = 1'b0;
        hresp_s     = HRESP_ERROR;
      end
      ST_ERR2: begin
        hreadyout_s = 1'b1;
        hresp_s     = HRESP_ERROR;
      end
      default: begin
        hreadyout_s = 1'b1;
        hresp_s     = HRESP_OKAY;
      end
    endcase
  end

  // Occupancy after this edge, used for the DMA request.
  always_comb begin
    if (push_s && !pop_s) begin
      fifo_count_next_s = fifo_count + CNTW'(1);
    end else if (pop_s && !push_s) begin
      fifo_count_next_s = fifo_count - CNTW'(1);
    end else begin
      fifo_count_next_s = fifo_count;
    end
  end

  // DMA request: asserted while the FIFO will still have a free entry.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_req_r <= 1'b0;
    end else begin
      data_req_r <= (fifo_count_next_s < CNTW'(DEPTH));
    end
  end

  wrapper_packet_fifo #(
    .WIDTH (PACKETWIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .push       (push_s),
    .push_data  ({last_s, merged_s}),
    .pop        (pop_s),
    .head_data  (fifo_head_s),
    .head_valid (packet_data_valid),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .count      (fifo_count)
  );

  assign packet_data      = fifo_head_s[PACKETWIDTH-1:0];
  assign packet_data_last = fifo_head_s[PACKETWIDTH];
  assign data_req         = data_req_r;
  assign hreadyouts       = hreadyout_s;
  assign hresps           = hresp_s;
  assign hrdatas          = 32'h0000_0000;

endmodule

// File: tb/tb_wrapper_ahb_packet_builder.sv
module tb_wrapper_ahb_packet_builder;

  localparam int PW    = 512;
  localparam int AW    = 11;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          hsels;
  logic [AW-1:0] haddrs;
  logic [1:0]    htranss;
  logic [2:0]    hsizes;
  logic          hwrites;
  logic          hreadys;
  logic [31:0]   hwdatas;
  logic          hreadyouts;
  logic          hresps;
  logic [31:0]   hrdatas;
  logic [PW-1:0] packet_data;
  logic          packet_data_last;
  logic          packet_data_valid;
  logic          packet_data_ready;
  logic          data_req;
  logic [CW-1:0] fifo_count;

  typedef struct packed {
    logic          last;
    logic [PW-1:0] data;
  } pkt_t;

  pkt_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   last_waits;
  logic last_resp;

  assign hreadys = hreadyouts;

  always #5 HCLK = ~HCLK;

  wrapper_ahb_packet_builder #(
    .ADDRWIDTH   (AW),
    .PACKETWIDTH (PW),
    .DEPTH       (DEPTH)
  ) dut (
    .HCLK              (HCLK),
    .HRESETn           (HRESETn),
    .hsels             (hsels),
    .haddrs            (haddrs),
    .htranss           (htranss),
    .hsizes            (hsizes),
    .hwrites           (hwrites),
    .hreadys           (hreadys),
    .hwdatas           (hwdatas),
    .hreadyouts        (hreadyouts),
    .hresps            (hresps),
    .hrdatas           (hrdatas),
    .packet_data       (packet_data),
    .packet_data_last  (packet_data_last),
    .packet_data_valid (packet_data_valid),
    .packet_data_ready (packet_data_ready),
    .data_req          (data_req),
    .fifo_count        (fifo_count)
  );

  task automatic check(input string name, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted packet is compared with the oldest expectation.
  always @(negedge HCLK) begin
    pkt_t e;
    if (HRESETn && packet_data_valid && packet_data_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_packet: got %0h expected none", packet_data);
      end else begin
        e = exp_q.pop_front();
        check("pkt_data", packet_data, e.data);
        check("pkt_last", PW'(packet_data_last), PW'(e.last));
      end
    end
  end

  // One non-pipelined AHB transfer; returns after the data phase's last cycle.
  task automatic ahb_xfer(input logic [AW-1:0] a, input logic [2:0] sz,
                          input logic [31:0] d, input logic wr);
    int waits = 0;
    @(posedge HCLK); #1;
    hsels = 1'b1; haddrs = a; htranss = 2'b10; hwrites = wr; hsizes = sz;
    @(posedge HCLK); #1;
    hsels = 1'b0; htranss = 2'b00; hwrites = 1'b0; hwdatas = d;
    @(negedge HCLK);
    while (!hreadyouts && waits < 40) begin
      waits++;
      @(negedge HCLK);
    end
    if (!hreadyouts) begin
      n_vec++;
      n_miss++;
      $display("FAIL hready_timeout: got 0 expected 1 at addr %0h", a);
    end
    last_waits = waits;
    last_resp  = hresps;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    ahb_xfer(a, 3'd2, d, 1'b1);
  endtask

  task automatic expect_pkt(input logic [PW-1:0] data, input logic last);
    pkt_t e;
    e.data = data;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int c = 0;
    @(posedge HCLK); #1;
    packet_data_ready = 1'b1;
    @(negedge HCLK);
    while (fifo_count != 0 && c < 20) begin
      c++;
      @(negedge HCLK);
    end
    @(posedge HCLK); #1;
    packet_data_ready = 1'b0;
    check("drain_count", PW'(fifo_count), PW'(0));
    check("drain_queue", PW'(exp_q.size()), PW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] p;
    HRESETn = 1'b0; hsels = 1'b0; haddrs = '0; htranss = 2'b00; hsizes = 3'd2;
    hwrites = 1'b0; hwdatas = 32'h0; packet_data_ready = 1'b0;

    // Reset values
    #1;
    check("rst_hready", PW'(hreadyouts), PW'(1));
    check("rst_hresp", PW'(hresps), PW'(0));
    check("rst_valid", PW'(packet_data_valid), PW'(0));
    check("rst_data_req", PW'(data_req), PW'(0));
    check("rst_count", PW'(fifo_count), PW'(0));
    check("rst_data", packet_data, {PW{1'b0}});
    repeat (2) @(negedge HCLK);
    #2 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    check("rel_data_req", PW'(data_req), PW'(1));
    check("rel_valid", PW'(packet_data_valid), PW'(0));
    check("rel_count", PW'(fifo_count), PW'(0));

    // 16 sequential words, word i = i
    p = '0;
    for (int i = 0; i < 16; i++) p[i*32 +: 32] = 32'(i);
    expect_pkt(p, 1'b0);
    for (int i = 0; i < 16; i++) begin
      wr(AW'(i * 4), 32'(i));
      check("seq_waits", PW'(last_waits), PW'(0));
    end
    check("valid_in_dphase", PW'(packet_data_valid), PW'(0));
    @(negedge HCLK);
    check("valid_after", PW'(packet_data_valid), PW'(1));
    check("count_one", PW'(fifo_count), PW'(1));
    drain();

    // Only the top word written
    p = '0;
    p[511:480] = 32'hDEAD_BEEF;
    expect_pkt(p, 1'b0);
    wr(11'h07C, 32'hDEAD_BEEF);
    @(negedge HCLK);
    check("top_valid", PW'(packet_data_valid), PW'(1));
    drain();

    // Fill the FIFO, stall the third completion, release with a one-cycle pop
    p = '0; p[511:480] = 32'hA0A0_0001; expect_pkt(p, 1'b0);
    p = '0; p[511:480] = 32'hB0B0_0002; expect_pkt(p, 1'b0);
    p = '0; p[511:480] = 32'hC0C0_0003; expect_pkt(p, 1'b0);
    wr(11'h03C, 32'hA0A0_0001);
    check("fill1_waits", PW'(last_waits), PW'(0));
    wr(11'h07C, 32'hB0B0_0002);
    check("fill2_waits", PW'(last_waits), PW'(0));
    @(negedge HCLK);
    check("full_count", PW'(fifo_count), PW'(2));
    check("full_data_req", PW'(data_req), PW'(0));
    fork
      wr(11'h0BC, 32'hC0C0_0003);
      begin
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("stall_hready", PW'(hreadyouts), PW'(0));
        check("stall_count", PW'(fifo_count), PW'(2));
        @(posedge HCLK); #1;
        packet_data_ready = 1'b1;
        @(posedge HCLK); #1;
        packet_data_ready = 1'b0;
      end
    join
    check("stall_waits", PW'(last_waits), PW'(2));
    @(negedge HCLK);
    check("release_count", PW'(fifo_count), PW'(2));
    check("release_data_req", PW'(data_req), PW'(0));
    drain();

    // Last flag from the top packet slot
    p = '0; p[511:480] = 32'h1357_9BDF; expect_pkt(p, 1'b1);
    p = '0; p[511:480] = 32'h2468_ACE0; expect_pkt(p, 1'b0);
    wr(11'h7FC, 32'h1357_9BDF);
    wr(11'h03C, 32'h2468_ACE0);
    drain();

    // Read gives zero-wait OKAY with zero data
    ahb_xfer(11'h040, 3'd2, 32'hFFFF_FFFF, 1'b0);
    check("read_waits", PW'(last_waits), PW'(0));
    check("read_resp", PW'(last_resp), PW'(0));
    check("read_data", PW'(hrdatas), PW'(0));

    // Byte write at offset 1 between word 0 and the completing word
    p = '0;
`ifdef WRAPPER_PACKET_BUILDER_SUBWORD_EN
    p[31:0] = 32'h1122_CC44;
`else
    p[31:0] = 32'h1122_3344;
`endif
    p[511:480] = 32'h5566_7788;
    expect_pkt(p, 1'b0);
    wr(11'h000, 32'h1122_3344);
    ahb_xfer(11'h001, 3'd0, 32'hAABB_CCDD, 1'b1);
`ifdef WRAPPER_PACKET_BUILDER_SUBWORD_EN
    check("byte_resp", PW'(last_resp), PW'(0));
    check("byte_waits", PW'(last_waits), PW'(0));
`else
    check("byte_resp", PW'(last_resp), PW'(1));
    check("byte_waits", PW'(last_waits), PW'(1));
`endif
    wr(11'h03C, 32'h5566_7788);
    drain();

    // Reset during a stall
    wr(11'h03C, 32'h0000_0011);
    wr(11'h07C, 32'h0000_0022);
    fork
      wr(11'h0BC, 32'h0000_0033);
      begin
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("pre_rst_hready", PW'(hreadyouts), PW'(0));
        #2 HRESETn = 1'b0;
        #1;
        check("mid_rst_hready", PW'(hreadyouts), PW'(1));
        check("mid_rst_valid", PW'(packet_data_valid), PW'(0));
        check("mid_rst_count", PW'(fifo_count), PW'(0));
        check("mid_rst_data_req", PW'(data_req), PW'(0));
        @(negedge HCLK);
        HRESETn = 1'b1;
      end
    join
    @(posedge HCLK); #1;
    check("post_rst_data_req", PW'(data_req), PW'(1));
    check("post_rst_count", PW'(fifo_count), PW'(0));
    check("final_queue", PW'(exp_q.size()), PW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
